// File: rtl/sprite_line_fetcher.sv
// Purpose: per-line sprite row fetch from sprite ROM into a line buffer, replayed at sprite_x as RGB+hit.
// Latency: fetch takes SPR_W+ROM_LAT+1 clocks after line_start; display path is 1 clock from hcount/video_on.
// Backpressure: none; line_start always wins (aborts/restarts), video_on during fetch is flagged as overrun.
module sprite_line_fetcher #(
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 48,
  parameter int          COORD_W = 10,
  parameter int          ROM_LAT = 1,
  parameter logic [23:0] KEY_RGB = 24'h00FF00
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               line_start,
  input  logic [COORD_W-1:0] next_line,
  input  logic [2:0]         sprite_sel,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [COORD_W-1:0] hcount,
  input  logic               video_on,
  output logic [2:0]         rom_sprite_index,
  output logic [63:0]        rom_sprite_row,
  output logic [63:0]        rom_pixel_index,
  input  logic [23:0]        rom_data,
  output logic               fetch_busy,
  output logic               fetch_overrun,
  output logic [23:0]        pix_rgb,
  output logic               pix_hit
);

  localparam int IDX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [COORD_W-1:0] SPR_W_C  = COORD_W'(SPR_W);
  localparam logic [COORD_W-1:0] SPR_H_C  = COORD_W'(SPR_H);
  localparam logic [IDX_W-1:0]   COL_LAST = IDX_W'(SPR_W - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(ROM_LAT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVAL  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]         state;
  logic [2:0]         sel_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] line_q;
  logic [COORD_W-1:0] row_q;
  logic [IDX_W-1:0]   col;
  logic [LAT_W-1:0]   drain_cnt;
  logic               line_valid;

  // Column tags travel alongside the ROM pipeline so each return lands in its own slot.
  logic               tag_vld [ROM_LAT];
  logic [IDX_W-1:0]   tag_col [ROM_LAT];

  logic [23:0]        line_buf [SPR_W];

  logic [COORD_W-1:0] d;
  logic [23:0]        buf_px;
  logic               in_range;
  logic               hit;
  logic               in_fetch;

  assign fetch_busy = (state != IDLE);
  assign in_fetch   = (state == FETCH) || (state == DRAIN);

  // Sequencer: line_start latches the sprite context from any state; EVAL decides fetch or skip.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sel_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      line_q     <= '0;
      row_q      <= '0;
      col        <= '0;
      drain_cnt  <= '0;
      line_valid <= 1'b0;
    end else if (line_start) begin
      sel_q      <= sprite_sel;
      x_q        <= sprite_x;
      y_q        <= sprite_y;
      line_q     <= next_line;
      row_q      <= next_line - sprite_y;
      col        <= '0;
      drain_cnt  <= '0;
      line_valid <= 1'b0;
      state      <= EVAL;
    end else begin
      case (state)
        EVAL: begin
          if ((line_q >= y_q) && (row_q < SPR_H_C)) begin
            col   <= '0;
            state <= FETCH;
          end else begin
            line_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        FETCH: begin
          if (col == COL_LAST) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_LAST) begin
            line_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM address is only driven while fetching so the ROM bus idles at zero.
  always_comb begin
    rom_sprite_index = '0;
    rom_sprite_row   = '0;
    rom_pixel_index  = '0;
    if (state == FETCH) begin
      rom_sprite_index = sel_q;
      rom_sprite_row   = 64'(row_q);
      rom_pixel_index  = 64'(col);
    end
  end

  // Tag shift register; an aborting line_start drops any returns still in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_col[i] <= '0;
      end
    end else if (line_start) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i] <= 1'b0;
      end
    end else begin
      tag_vld[0] <= (state == FETCH);
      tag_col[0] <= col;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_col[i] <= tag_col[i-1];
      end
    end
  end

  // Line buffer write; contents are meaningless until line_valid so no reset is needed.
  always_ff @(posedge clock) begin
    if (tag_vld[ROM_LAT-1] && !line_start) begin
      line_buf[tag_col[ROM_LAT-1]] <= rom_data;
    end
  end

  // Sticky overrun: display touched the buffer mid-fetch, or a new line arrived before the old one finished.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetch_overrun <= 1'b0;
    end else if ((video_on && fetch_busy) || (line_start && in_fetch)) begin
      fetch_overrun <= 1'b1;
    end
  end

  // Hit test against the latched sprite position; hcount left of sprite_x wraps d but is rejected by the >= term.
  always_comb begin
    d        = hcount - x_q;
    in_range = (hcount >= x_q) && (d < SPR_W_C);
    buf_px   = line_buf[d[IDX_W-1:0]];
    hit      = video_on && line_valid && !fetch_busy && in_range && (buf_px != KEY_RGB);
  end

  // Registered pixel output, colour forced to zero on a miss.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_hit <= 1'b0;
      pix_rgb <= '0;
    end else begin
      pix_hit <= hit;
      pix_rgb <= hit ? buf_px : 24'h0;
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Purpose: directed self-checking bench for sprite_line_fetcher with a 1-clock behavioural sprite ROM.
// Latency: checks fetch length, ROM address sequence and the 1-clock display path.
// Backpressure: exercises abort-by-line_start and video_on-during-fetch overrun.
module tb_sprite_line_fetcher;

  localparam logic [23:0] KEY = 24'h00FF00;

  logic        clock;
  logic        resetn;
  logic        line_start;
  logic [9:0]  next_line;
  logic [2:0]  sprite_sel;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  hcount;
  logic        video_on;
  logic [2:0]  rom_sprite_index;
  logic [63:0] rom_sprite_row;
  logic [63:0] rom_pixel_index;
  logic [23:0] rom_data;
  logic        fetch_busy;
  logic        fetch_overrun;
  logic [23:0] pix_rgb;
  logic        pix_hit;

  int checks;
  int errors;
  int key_col;
  int busy_cnt;
  int fetch_cnt;
  int seq_bad;
  int hits;

  sprite_line_fetcher dut (
    .clock            (clock),
    .resetn           (resetn),
    .line_start       (line_start),
    .next_line        (next_line),
    .sprite_sel       (sprite_sel),
    .sprite_x         (sprite_x),
    .sprite_y         (sprite_y),
    .hcount           (hcount),
    .video_on         (video_on),
    .rom_sprite_index (rom_sprite_index),
    .rom_sprite_row   (rom_sprite_row),
    .rom_pixel_index  (rom_pixel_index),
    .rom_data         (rom_data),
    .fetch_busy       (fetch_busy),
    .fetch_overrun    (fetch_overrun),
    .pix_rgb          (pix_rgb),
    .pix_hit          (pix_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sprite ROM content: unique per (sprite,row,col), never the key unless injected at key_col.
  function automatic logic [23:0] rom_val(input logic [2:0] s, input logic [63:0] r, input logic [63:0] c);
    if (key_col >= 0 && c == 64'(key_col)) return KEY;
    return {4'h1, 1'b0, s, r[7:0], c[7:0]};
  endfunction

  // One-clock-latency ROM.
  always @(posedge clock) rom_data <= rom_val(rom_sprite_index, rom_sprite_row, rom_pixel_index);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [2:0] s, input logic [9:0] x, input logic [9:0] y, input logic [9:0] ln);
    sprite_sel = s;
    sprite_x   = x;
    sprite_y   = y;
    next_line  = ln;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Watch 40 clocks after line_start: busy length, fetched addresses and row.
  task automatic observe(input logic [63:0] exp_row);
    busy_cnt  = 0;
    fetch_cnt = 0;
    seq_bad   = 0;
    for (int c = 1; c <= 40; c++) begin
      if (fetch_busy) busy_cnt++;
      if (rom_sprite_index != 3'd0) begin
        if (rom_pixel_index != 64'(fetch_cnt) || rom_sprite_row != exp_row) seq_bad++;
        fetch_cnt++;
      end
      tick();
    end
  endtask

  task automatic pixel(input logic [9:0] hc);
    video_on = 1'b1;
    hcount   = hc;
    tick();
    video_on = 1'b0;
  endtask

  task automatic sweep(input int lo, input int hi);
    hits = 0;
    for (int h = lo; h <= hi; h++) begin
      video_on = 1'b1;
      hcount   = 10'(h);
      tick();
      if (pix_hit) hits++;
    end
    video_on = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    key_col    = -1;
    resetn     = 1'b0;
    line_start = 1'b0;
    next_line  = '0;
    sprite_sel = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    hcount     = '0;
    video_on   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 64'(fetch_busy), 0);
    chk("rst_overrun", 64'(fetch_overrun), 0);
    chk("rst_hit", 64'(pix_hit), 0);
    chk("rst_rgb", 64'(pix_rgb), 0);
    chk("rst_rom_idx", 64'(rom_sprite_index), 0);
    chk("rst_rom_col", rom_pixel_index, 0);
    resetn = 1'b1;
    tick();

    // Row 0 fetch and first pixel
    start_line(3'd2, 10'd200, 10'd100, 10'd100);
    observe(64'd0);
    chk("row0_busy_len", 64'(busy_cnt), 34);
    chk("row0_fetch_cnt", 64'(fetch_cnt), 32);
    chk("row0_seq", 64'(seq_bad), 0);
    pixel(10'd200);
    chk("row0_c0_hit", 64'(pix_hit), 1);
    chk("row0_c0_rgb", 64'(pix_rgb), 64'(rom_val(3'd2, 64'd0, 64'd0)));

    // Lines outside the sprite
    start_line(3'd2, 10'd200, 10'd100, 10'd99);
    observe(64'd0);
    chk("l99_fetch_cnt", 64'(fetch_cnt), 0);
    chk("l99_busy_len", 64'(busy_cnt), 1);
    sweep(190, 240);
    chk("l99_hits", 64'(hits), 0);
    start_line(3'd2, 10'd200, 10'd100, 10'd148);
    observe(64'd0);
    chk("l148_fetch_cnt", 64'(fetch_cnt), 0);
    sweep(190, 240);
    chk("l148_hits", 64'(hits), 0);

    // Last sprite row
    start_line(3'd2, 10'd200, 10'd100, 10'd147);
    observe(64'd47);
    chk("l147_fetch_cnt", 64'(fetch_cnt), 32);
    chk("l147_seq", 64'(seq_bad), 0);
    pixel(10'd203);
    chk("l147_c3_rgb", 64'(pix_rgb), 64'(rom_val(3'd2, 64'd47, 64'd3)));

    // Colour key at column 5
    key_col = 5;
    start_line(3'd3, 10'd300, 10'd100, 10'd110);
    observe(64'd10);
    key_col = -1;
    pixel(10'd305);
    chk("key_c5_hit", 64'(pix_hit), 0);
    chk("key_c5_rgb", 64'(pix_rgb), 0);
    pixel(10'd304);
    chk("key_c4_hit", 64'(pix_hit), 1);
    chk("key_c4_rgb", 64'(pix_rgb), 64'(rom_val(3'd3, 64'd10, 64'd4)));
    pixel(10'd306);
    chk("key_c6_rgb", 64'(pix_rgb), 64'(rom_val(3'd3, 64'd10, 64'd6)));
    sweep(298, 334);
    chk("key_hits", 64'(hits), 31);

    // Horizontal edges
    pixel(10'd331);
    chk("edge_c31_hit", 64'(pix_hit), 1);
    chk("edge_c31_rgb", 64'(pix_rgb), 64'(rom_val(3'd3, 64'd10, 64'd31)));
    pixel(10'd332);
    chk("edge_c32_hit", 64'(pix_hit), 0);
    pixel(10'd299);
    chk("edge_left_hit", 64'(pix_hit), 0);

    // Right-screen clip at sprite_x=630
    start_line(3'd3, 10'd630, 10'd100, 10'd110);
    observe(64'd10);
    sweep(620, 639);
    chk("clip_hits", 64'(hits), 10);
    chk("clip_c9_rgb", 64'(pix_rgb), 64'(rom_val(3'd3, 64'd10, 64'd9)));

    // video_on during fetch, then restart during FETCH
    chk("ovr_pre", 64'(fetch_overrun), 0);
    start_line(3'd4, 10'd100, 10'd100, 10'd110);
    for (int i = 0; i < 9; i++) tick();
    video_on = 1'b1;
    hcount   = 10'd105;
    tick();
    chk("ovr_hit", 64'(pix_hit), 0);
    video_on = 1'b0;
    tick();
    chk("ovr_set", 64'(fetch_overrun), 1);
    start_line(3'd4, 10'd100, 10'd100, 10'd120);
    observe(64'd20);
    chk("restart_busy_len", 64'(busy_cnt), 34);
    chk("restart_fetch_cnt", 64'(fetch_cnt), 32);
    chk("restart_seq", 64'(seq_bad), 0);
    pixel(10'd107);
    chk("restart_c7_rgb", 64'(pix_rgb), 64'(rom_val(3'd4, 64'd20, 64'd7)));
    chk("ovr_sticky", 64'(fetch_overrun), 1);

    // Reset asserted mid-FETCH
    start_line(3'd1, 10'd50, 10'd100, 10'd105);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 64'(fetch_busy), 1);
    resetn = 1'b0;
    tick();
    chk("mrst_busy", 64'(fetch_busy), 0);
    chk("mrst_hit", 64'(pix_hit), 0);
    chk("mrst_rgb", 64'(pix_rgb), 0);
    chk("mrst_rom_idx", 64'(rom_sprite_index), 0);
    chk("mrst_rom_row", rom_sprite_row, 0);
    chk("mrst_rom_col", rom_pixel_index, 0);
    chk("mrst_overrun", 64'(fetch_overrun), 0);
    resetn = 1'b1;
    tick();
    pixel(10'd51);
    chk("mrst_no_line", 64'(pix_hit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
